// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one write port,
// write-through bypass and a committed-write counter.
module reg_file #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(128)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [15:0]       write_cnt
);

  logic [DATA_W-1:0] regs [32];
  logic              wr_en;

  assign wr_en = reg_write && (rd_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[29]  <= SP_INIT;
      write_cnt <= '0;
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
      write_cnt     <= write_cnt + 16'd1;
    end
  end

  // r0 is hardwired; bypass only forwards writes that will actually commit
  always_comb begin
    rs_data = regs[rs_addr];
    unique case (1'b1)
      (rs_addr == 5'd0):                      rs_data = '0;
      (!rst && wr_en && rs_addr == rd_addr):  rs_data = rd_data;
      default:                                rs_data = regs[rs_addr];
    endcase
  end

  always_comb begin
    rt_data = regs[rt_addr];
    unique case (1'b1)
      (rt_addr == 5'd0):                      rt_data = '0;
      (!rst && wr_en && rt_addr == rd_addr):  rt_data = rd_data;
      default:                                rt_data = regs[rt_addr];
    endcase
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, r0, bypass,
// reset priority, reset mid-sequence and counter wrap.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] rs_data, rt_data;
  logic [15:0] write_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .SP_INIT(32'd128)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .reg_write (reg_write),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .write_cnt (write_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rs_addr = a;
    rt_addr = b;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = '0; rt_addr = '0; rd_addr = '0;
    rd_data = '0; reg_write = 1'b0;
    step();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk($sformatf("rst_rs%0d", i), rs_data, (i == 29) ? 32'd128 : 32'd0);
      chk($sformatf("rst_rt%0d", 31 - i), rt_data,
          (31 - i == 29) ? 32'd128 : 32'd0);
    end
    chk("rst_cnt", {16'd0, write_cnt}, 32'd0);

    rd_addr = 5'd5; rd_data = 32'hDEADBEEF; reg_write = 1'b1;
    step();
    reg_write = 1'b0;
    rd(5'd5, 5'd5);
    chk("wr5_rs", rs_data, 32'hDEADBEEF);
    chk("wr5_rt", rt_data, 32'hDEADBEEF);
    chk("wr5_cnt", {16'd0, write_cnt}, 32'd1);

    rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; reg_write = 1'b1;
    rd(5'd0, 5'd0);
    chk("r0_byp_rs", rs_data, 32'd0);
    chk("r0_byp_rt", rt_data, 32'd0);
    step();
    reg_write = 1'b0;
    rd(5'd0, 5'd5);
    chk("r0_rs", rs_data, 32'd0);
    chk("r0_r5", rt_data, 32'hDEADBEEF);
    chk("r0_cnt", {16'd0, write_cnt}, 32'd1);

    rd(5'd7, 5'd7);
    chk("r7_pre", rs_data, 32'd0);
    rd_addr = 5'd7; rd_data = 32'h12345678; reg_write = 1'b1;
    rd(5'd7, 5'd7);
    chk("byp_rs", rs_data, 32'h12345678);
    chk("byp_rt", rt_data, 32'h12345678);
    step();
    reg_write = 1'b0;
    rd(5'd7, 5'd5);
    chk("byp_post_rs", rs_data, 32'h12345678);
    chk("byp_post_rt", rt_data, 32'hDEADBEEF);
    chk("byp_cnt", {16'd0, write_cnt}, 32'd2);

    rd_addr = 5'd5; rd_data = 32'h0BADF00D; reg_write = 1'b0;
    step();
    rd(5'd5, 5'd7);
    chk("nowe_r5", rs_data, 32'hDEADBEEF);
    chk("nowe_cnt", {16'd0, write_cnt}, 32'd2);

    rst = 1'b1;
    rd_addr = 5'd29; rd_data = 32'hAAAA5555; reg_write = 1'b1;
    rd(5'd29, 5'd7);
    chk("rstpri_pre29", rs_data, 32'd128);
    chk("rstpri_pre7", rt_data, 32'h12345678);
    step();
    rst = 1'b0; reg_write = 1'b0;
    rd(5'd29, 5'd7);
    chk("rstpri_r29", rs_data, 32'd128);
    chk("rstpri_r7", rt_data, 32'd0);
    chk("rstpri_cnt", {16'd0, write_cnt}, 32'd0);

    rd_addr = 5'd3; rd_data = 32'h11; reg_write = 1'b1;
    step();
    rd_addr = 5'd4; rd_data = 32'h22;
    step();
    rst = 1'b1; rd_addr = 5'd6; rd_data = 32'h33;
    step();
    rst = 1'b0; reg_write = 1'b0;
    rd(5'd3, 5'd4);
    chk("mid_r3", rs_data, 32'd0);
    chk("mid_r4", rt_data, 32'd0);
    rd(5'd6, 5'd29);
    chk("mid_r6", rs_data, 32'd0);
    chk("mid_r29", rt_data, 32'd128);
    chk("mid_cnt", {16'd0, write_cnt}, 32'd0);
    rd_addr = 5'd8; rd_data = 32'h44; reg_write = 1'b1;
    step();
    reg_write = 1'b0;
    rd(5'd8, 5'd0);
    chk("mid_r8", rs_data, 32'h44);
    chk("mid_cnt1", {16'd0, write_cnt}, 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_addr = 5'd1; reg_write = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      rd_data = 32'hCAFE0000 | 32'(i);
      step();
    end
    reg_write = 1'b0;
    #1;
    chk("wrap_ffff", {16'd0, write_cnt}, 32'h0000FFFF);
    rd_data = 32'hCAFEFFFF; reg_write = 1'b1;
    step();
    reg_write = 1'b0;
    rd(5'd1, 5'd1);
    chk("wrap_cnt", {16'd0, write_cnt}, 32'd0);
    chk("wrap_r1", rs_data, 32'hCAFEFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
